regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Sequencer/arbiter for the 32x64 register file's write port and read port 2.
//  After reset it clears X0..X30 to zero, stalling the pipeline while it does so.
//  It then shares the write port between pipeline writeback (always wins) and a debug port.
//  Debug reads steal read port 2 only when decode leaves that port free.
// PARAMETERS
//  DW        64   data width
//  AW        5    register address width
//  INIT_ZERO 1    1: sweep-clear X0..X30 after reset; 0: start in IDLE
//  MAX_WAIT  15   cycles a debug request may wait before forcing a pipeline stall
// PORTS
//  clk            in   1   system clock, posedge logic (regfile itself writes on negedge)
//  reset_n        in   1   asynchronous, active-low reset
//  wb_en          in   1   pipeline writeback valid
//  wb_addr        in   AW  writeback destination
//  wb_data        in   DW  writeback data
//  rd2_free       in   1   decode not using read port 2 this cycle
//  rf_D2          in   DW  regfile ReadData2
//  dbg_req        in   1   debug request; held with addr/we/wdata stable until dbg_ack
//  dbg_we         in   1   1 = write, 0 = read
//  dbg_addr       in   AW  debug register index
//  dbg_wdata      in   DW  debug write data
//  dbg_ack        out  1   one-cycle completion pulse
//  dbg_rdata      out  DW  read result, valid while dbg_ack=1, held until next read
//  dbg_stall_req  out  1   asks the pipeline to hold wb_en=0 and rd2_free=1
//  init_busy      out  1   pipeline must stall (no wb_en) while high
//  rf_RegWrite    out  1   regfile write enable
//  rf_Rd_write    out  AW  regfile write address
//  rf_RegDataIn   out  DW  regfile write data
//  rf_rd2_ovr     out  1   force read port 2 address to rf_rd2_addr
//  rf_rd2_addr    out  AW  override read address
// BEHAVIOUR
//  - Reset values: state = INIT (IDLE if INIT_ZERO=0), init_idx=0, init_busy=INIT_ZERO,
//    dbg_ack=0, dbg_rdata=0, dbg_stall_req=0, wait_cnt=0.
//  - A reset asserted mid-sweep restarts the sweep at X0. A reset mid-request drops the
//    request with no ack.
//  - Write-port outputs and rf_rd2_* are combinational from state and inputs.
//    All other outputs are registered.
//  - INIT: rf_RegWrite=1, rf_Rd_write=init_idx, rf_RegDataIn=0; init_idx++ every cycle.
//    After the write to X30 (31 cycles), go to IDLE and drop init_busy the same edge.
//    wb_en is ignored in INIT; dbg_req stays pending and is not acked.
//  - IDLE/WAIT write port: if wb_en, pass wb_* through, with rf_RegWrite = wb_en & (wb_addr != 31).
//  - Debug write is serviceable when wb_en=0. It drives the write port with dbg_*.
//    Any write to 31 is suppressed (rf_RegWrite=0) but still acked.
//  - Debug read is serviceable when rd2_free=1. It drives rf_rd2_ovr=1 and rf_rd2_addr=dbg_addr,
//    then captures rf_D2 into dbg_rdata at that posedge. Address 31 returns 0.
//  - Same-cycle wb write to the same address as a debug read: the read returns the NEW value
//    (negedge regfile write precedes the posedge capture).
//  - FSM INIT -> IDLE -> {ACK | WAIT} -> ACK -> IDLE:
//    - IDLE + dbg_req: if serviceable, service this cycle and go to ACK; else go to WAIT.
//    - WAIT: service on the first serviceable cycle, then go to ACK. Otherwise increment
//      wait_cnt (saturating). When wait_cnt reaches MAX_WAIT, set dbg_stall_req=1.
//    - ACK: dbg_ack=1 for exactly one cycle. Clear wait_cnt and dbg_stall_req. dbg_req is
//      ignored in this cycle; return to IDLE. Back-to-back requests therefore take >= 2 cycles each.
//  - Latency: debug op acked 1 cycle after service. Best case is 1 cycle from dbg_req.
//  - The pipeline's writeback is never delayed by this block.
// STRUCTURE
//  - regfile_ctrl_pkg holds:
//    - typedef enum logic [1:0] {INIT, IDLE, WAIT, ACK} rfc_state_t;
//    - localparam XZR = 5'd31;
//    - localparam LAST_INIT = 5'd30.
//  - One sub-module, sat_counter #(W, MAX): wait counter with clear, enable and at_max flag.
//  - Otherwise a single FSM plus combinational port muxes.
// TESTING
//  - Reset then run: 31 cycles with rf_RegWrite=1 at addresses 0..30 and data 0; init_busy
//    falls on cycle 31. Address 31 is never written.
//  - Reset at init cycle 10: on release, the sweep restarts at X0 and takes a full 31 cycles.
//  - IDLE, wb_en=0, debug write X5=0xDEAD_BEEF: rf_RegWrite=1, Rd_write=5 the same cycle;
//    dbg_ack next cycle.
//  - Debug read X7 with rd2_free=0 for 20 cycles: dbg_stall_req=1 after 15 waiting cycles.
//    Raise rd2_free: ack next cycle, dbg_rdata=X7, stall_req cleared.
//  - Debug write X3 while wb_en=1 to X9 for 4 cycles: only wb writes occur. The debug write
//    lands the cycle wb_en drops; X9 is untouched.
//  - wb writes X4=0x1234 in the same cycle as a debug read of X4 with rd2_free=1:
//    dbg_rdata=0x1234. Debug write to X31: acked, rf_RegWrite=0.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, ACK} rfc_state_t;

  localparam logic [4:0] XZR       = 5'd31;
  localparam logic [4:0] LAST_INIT = 5'd30;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Pipeline, debug and regfile-side signals of the write port / read port 2 controller.
interface regfile_port_ctrl_if #(
  parameter int DW = 64,
  parameter int AW = 5
);

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rd2_free;
  logic [DW-1:0] rf_D2;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_stall_req;
  logic          init_busy;

  logic          rf_RegWrite;
  logic [AW-1:0] rf_Rd_write;
  logic [DW-1:0] rf_RegDataIn;
  logic          rf_rd2_ovr;
  logic [AW-1:0] rf_rd2_addr;

  modport slave (
    input  wb_en, wb_addr, wb_data, rd2_free, rf_D2,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_stall_req, init_busy,
    output rf_RegWrite, rf_Rd_write, rf_RegDataIn, rf_rd2_ovr, rf_rd2_addr
  );

  modport master (
    output wb_en, wb_addr, wb_data, rd2_free, rf_D2,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_stall_req, init_busy,
    input  rf_RegWrite, rf_Rd_write, rf_RegDataIn, rf_rd2_ovr, rf_rd2_addr
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and an at-maximum flag.
module sat_counter #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Write-port / read-port-2 sequencer: post-reset clear sweep, then writeback-priority
// sharing of the write port with a debug port, and opportunistic debug reads on port 2.
module regfile_port_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int          DW        = 64,
  parameter int          AW        = 5,
  parameter bit          INIT_ZERO = 1'b1,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_port_ctrl_if.slave  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam rfc_state_t RST_STATE = INIT_ZERO ? INIT : IDLE;

  rfc_state_t    state, state_nx;
  logic [AW-1:0] init_idx;
  logic [CW-1:0] wait_cnt;
  logic          wait_at_max;
  logic          active, svc_ok, svc_now, rd_now;
  logic          cnt_en, cnt_clr, stall_set;

  always_comb begin
    active    = (state == IDLE) || (state == WAIT);
    svc_ok    = bus.dbg_we ? !bus.wb_en : bus.rd2_free;
    svc_now   = active && bus.dbg_req && svc_ok;
    rd_now    = svc_now && !bus.dbg_we;
    cnt_en    = (state == WAIT) && bus.dbg_req && !svc_ok;
    cnt_clr   = svc_now || (state == ACK) || ((state == WAIT) && !bus.dbg_req);
    stall_set = cnt_en && (wait_at_max || (wait_cnt == CW'(MAX_WAIT - 1)));
  end

  sat_counter #(
    .W   (CW),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (wait_cnt),
    .at_max  (wait_at_max)
  );

  always_comb begin
    state_nx         = state;
    bus.rf_RegWrite  = 1'b0;
    bus.rf_Rd_write  = '0;
    bus.rf_RegDataIn = '0;
    bus.rf_rd2_ovr   = 1'b0;
    bus.rf_rd2_addr  = '0;

    if (state == INIT) begin
      bus.rf_RegWrite = 1'b1;
      bus.rf_Rd_write = init_idx;
      if (init_idx == AW'(LAST_INIT)) state_nx = IDLE;
    end else begin
      // Writeback owns the port in every post-init state, ACK included.
      if (bus.wb_en) begin
        bus.rf_RegWrite  = (bus.wb_addr != AW'(XZR));
        bus.rf_Rd_write  = bus.wb_addr;
        bus.rf_RegDataIn = bus.wb_data;
      end else if (svc_now && bus.dbg_we) begin
        bus.rf_RegWrite  = (bus.dbg_addr != AW'(XZR));
        bus.rf_Rd_write  = bus.dbg_addr;
        bus.rf_RegDataIn = bus.dbg_wdata;
      end
      if (rd_now) begin
        bus.rf_rd2_ovr  = 1'b1;
        bus.rf_rd2_addr = bus.dbg_addr;
      end

      if (state == ACK)        state_nx = IDLE;
      else if (svc_now)        state_nx = ACK;
      else if (bus.dbg_req)    state_nx = WAIT;
      else                     state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= RST_STATE;
      init_idx          <= '0;
      bus.init_busy     <= INIT_ZERO;
      bus.dbg_ack       <= 1'b0;
      bus.dbg_rdata     <= '0;
      bus.dbg_stall_req <= 1'b0;
    end else begin
      state         <= state_nx;
      bus.init_busy <= (state_nx == INIT);
      bus.dbg_ack   <= (state_nx == ACK);
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (rd_now) bus.dbg_rdata <= (bus.dbg_addr == AW'(XZR)) ? '0 : bus.rf_D2;
      if (cnt_clr)        bus.dbg_stall_req <= 1'b0;
      else if (stall_set) bus.dbg_stall_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl with a negedge-write register file model and a debug scoreboard.
module tb_regfile_port_ctrl;

  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct {
    bit            is_read;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  regfile_port_ctrl #(
    .DW        (DW),
    .AW        (AW),
    .INIT_ZERO (1'b1),
    .MAX_WAIT  (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] regs [32];
  logic          model_ready = 1'b0;
  int            bad31 = 0;
  exp_t          exp_q [$];
  exp_t          e;
  int            vectors = 0;
  int            miscompares = 0;

  // Register file writes on negedge; read port 2 shows X31 when not overridden.
  always @(negedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 32; i++) regs[i] <= {32'hA5A5_5A5A, 32'(i)};
    end else if (bus.rf_RegWrite) begin
      regs[bus.rf_Rd_write] <= bus.rf_RegDataIn;
      if (bus.rf_Rd_write == 5'd31) bad31 <= bad31 + 1;
    end
  end
  assign bus.rf_D2 = bus.rf_rd2_ovr ? regs[bus.rf_rd2_addr] : regs[31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.rd2_free = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic dbg_drive(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.dbg_ack === 1'b1) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    int nz;
    idle_inputs();
    reset_n = 1'b0;
    tick(); tick();
    model_ready = 1'b1;
    vectors++;
    if ({bus.init_busy, bus.dbg_ack, bus.dbg_stall_req, bus.dbg_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_regs: got busy/ack/stall/rdata %b%b%b/%h, expected 100/0",
               bus.init_busy, bus.dbg_ack, bus.dbg_stall_req, bus.dbg_rdata);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      #1;
      vectors++;
      if ({bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.init_busy} !== {1'b1, 5'(i), 64'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL sweep[%0d]: got we=%b addr=%0d data=%h busy=%b, expected we=1 addr=%0d data=0 busy=1",
                 i, bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.init_busy, i);
      end
      tick();
    end
    vectors++;
    if ({bus.init_busy, bus.rf_RegWrite} !== 2'b00) begin
      miscompares++;
      $display("FAIL sweep_end: got busy=%b we=%b, expected busy=0 we=0", bus.init_busy, bus.rf_RegWrite);
    end
    nz = 0;
    for (int i = 0; i < 31; i++) if (regs[i] !== 64'd0) nz++;
    vectors++;
    if (nz != 0 || regs[31] !== {32'hA5A5_5A5A, 32'd31}) begin
      miscompares++;
      $display("FAIL sweep_contents: got %0d nonzero X0..X30, X31=%h, expected 0 nonzero, X31=a5a55a5a0000001f",
               nz, regs[31]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (bus.rf_Rd_write !== 5'd10) begin
      miscompares++;
      $display("FAIL mid_sweep_idx: got %0d, expected 10", bus.rf_Rd_write);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rf_Rd_write, bus.init_busy} !== {5'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset: got addr=%0d busy=%b, expected addr=0 busy=1", bus.rf_Rd_write, bus.init_busy);
    end
    tick();
    reset_n = 1'b1;
    dbg_drive(1'b1, 5'd2, 64'h55);
    exp_q.push_back('{is_read: 1'b0, addr: 5'd2, data: 64'h55});
    bus.wb_addr = 5'd9; bus.wb_data = 64'hBAD;
    for (int i = 0; i < 31; i++) begin
      bus.wb_en = (i < 30);
      #1;
      vectors++;
      if ({bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.dbg_ack} !== {1'b1, 5'(i), 64'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL resweep[%0d]: got we=%b addr=%0d data=%h ack=%b, expected we=1 addr=%0d data=0 ack=0",
                 i, bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.dbg_ack, i);
      end
      tick();
    end
    vectors++;
    if ({bus.init_busy, bus.rf_RegWrite, bus.rf_Rd_write} !== {1'b0, 1'b1, 5'd2}) begin
      miscompares++;
      $display("FAIL pending_write: got busy=%b we=%b addr=%0d, expected busy=0 we=1 addr=2",
               bus.init_busy, bus.rf_RegWrite, bus.rf_Rd_write);
    end
    tick();
    vectors++;
    e = exp_q.pop_front();
    if (bus.dbg_ack !== 1'b1 || regs[e.addr] !== e.data) begin
      miscompares++;
      $display("FAIL pending_ack: got ack=%b X2=%h, expected ack=1 X2=%h", bus.dbg_ack, regs[e.addr], e.data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dbg_write();
    dbg_drive(1'b1, 5'd5, 64'hDEAD_BEEF);
    exp_q.push_back('{is_read: 1'b0, addr: 5'd5, data: 64'hDEAD_BEEF});
    #1;
    vectors++;
    if ({bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn} !== {1'b1, 5'd5, 64'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL dbg_write_port: got we=%b addr=%0d data=%h, expected we=1 addr=5 data=deadbeef",
               bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (bus.dbg_ack !== 1'b1 || regs[e.addr] !== e.data) begin
      miscompares++;
      $display("FAIL dbg_write_ack: got ack=%b X5=%h, expected ack=1 X5=%h", bus.dbg_ack, regs[e.addr], e.data);
    end
    idle_inputs();
    tick();
    vectors++;
    if (bus.dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_one_cycle: got %b, expected 0", bus.dbg_ack);
    end
  endtask

  task automatic test_wait_stall();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 64'h7777;
    tick();
    bus.wb_en = 1'b0;
    dbg_drive(1'b0, 5'd7, '0);
    bus.rd2_free = 1'b0;
    exp_q.push_back('{is_read: 1'b1, addr: 5'd7, data: 64'h7777});
    for (int n = 1; n <= 20; n++) begin
      tick();
      vectors++;
      if ({bus.dbg_stall_req, bus.dbg_ack, bus.rf_rd2_ovr} !== {(n >= 16), 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL wait_stall[%0d]: got stall=%b ack=%b ovr=%b, expected stall=%b ack=0 ovr=0",
                 n, bus.dbg_stall_req, bus.dbg_ack, bus.rf_rd2_ovr, (n >= 16));
      end
    end
    bus.rd2_free = 1'b1;
    #1;
    vectors++;
    if ({bus.rf_rd2_ovr, bus.rf_rd2_addr} !== {1'b1, 5'd7}) begin
      miscompares++;
      $display("FAIL rd2_override: got ovr=%b addr=%0d, expected ovr=1 addr=7", bus.rf_rd2_ovr, bus.rf_rd2_addr);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({bus.dbg_ack, bus.dbg_stall_req, bus.dbg_rdata} !== {1'b1, 1'b0, e.data}) begin
      miscompares++;
      $display("FAIL wait_read_ack: got ack=%b stall=%b rdata=%h, expected ack=1 stall=0 rdata=%h",
               bus.dbg_ack, bus.dbg_stall_req, bus.dbg_rdata, e.data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wb_priority();
    dbg_drive(1'b1, 5'd3, 64'h33);
    exp_q.push_back('{is_read: 1'b0, addr: 5'd3, data: 64'h33});
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9;
    for (int i = 0; i < 4; i++) begin
      bus.wb_data = 64'h9000 + 64'(i);
      #1;
      vectors++;
      if ({bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.dbg_ack} !== {1'b1, 5'd9, 64'h9000 + 64'(i), 1'b0}) begin
        miscompares++;
        $display("FAIL wb_wins[%0d]: got we=%b addr=%0d data=%h ack=%b, expected we=1 addr=9 data=%h ack=0",
                 i, bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn, bus.dbg_ack, 64'h9000 + 64'(i));
      end
      tick();
    end
    bus.wb_en = 1'b0;
    #1;
    vectors++;
    if ({bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn} !== {1'b1, 5'd3, 64'h33}) begin
      miscompares++;
      $display("FAIL deferred_write: got we=%b addr=%0d data=%h, expected we=1 addr=3 data=33",
               bus.rf_RegWrite, bus.rf_Rd_write, bus.rf_RegDataIn);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (bus.dbg_ack !== 1'b1 || regs[e.addr] !== e.data || regs[9] !== 64'h9003) begin
      miscompares++;
      $display("FAIL deferred_ack: got ack=%b X3=%h X9=%h, expected ack=1 X3=%h X9=9003",
               bus.dbg_ack, regs[e.addr], regs[9], e.data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_cycle();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 64'h1234;
    dbg_drive(1'b0, 5'd4, '0);
    bus.rd2_free = 1'b1;
    exp_q.push_back('{is_read: 1'b1, addr: 5'd4, data: 64'h1234});
    tick();
    bus.wb_en = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if ({bus.dbg_ack, bus.dbg_rdata} !== {1'b1, e.data}) begin
      miscompares++;
      $display("FAIL same_cycle_read: got ack=%b rdata=%h, expected ack=1 rdata=%h", bus.dbg_ack, bus.dbg_rdata, e.data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_xzr();
    bit got;
    dbg_drive(1'b1, 5'd31, 64'hFFFF);
    exp_q.push_back('{is_read: 1'b0, addr: 5'd31, data: {32'hA5A5_5A5A, 32'd31}});
    #1;
    vectors++;
    if (bus.rf_RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL xzr_dbg_write: got we=%b, expected 0", bus.rf_RegWrite);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (bus.dbg_ack !== 1'b1 || regs[e.addr] !== e.data) begin
      miscompares++;
      $display("FAIL xzr_dbg_ack: got ack=%b X31=%h, expected ack=1 X31=%h", bus.dbg_ack, regs[e.addr], e.data);
    end
    idle_inputs();
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 64'hF00D;
    #1;
    vectors++;
    if (bus.rf_RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL xzr_wb_write: got we=%b, expected 0", bus.rf_RegWrite);
    end
    tick();
    idle_inputs();
    dbg_drive(1'b0, 5'd31, '0);
    bus.rd2_free = 1'b1;
    exp_q.push_back('{is_read: 1'b1, addr: 5'd31, data: 64'd0});
    tick();
    wait_ack(4, got);
    e = exp_q.pop_front();
    vectors++;
    if (!got || bus.dbg_rdata !== e.data) begin
      miscompares++;
      $display("FAIL xzr_read: got ack_seen=%b rdata=%h, expected ack_seen=1 rdata=%h", got, bus.dbg_rdata, e.data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.rd2_free = 1'b1;
    dbg_drive(1'b0, 5'd5, '0);
    exp_q.push_back('{is_read: 1'b1, addr: 5'd5, data: 64'hDEAD_BEEF});
    exp_q.push_back('{is_read: 1'b1, addr: 5'd7, data: 64'h7777});
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({bus.dbg_ack, bus.dbg_rdata} !== {1'b1, e.data}) begin
      miscompares++;
      $display("FAIL b2b_first: got ack=%b rdata=%h, expected ack=1 rdata=%h", bus.dbg_ack, bus.dbg_rdata, e.data);
    end
    bus.dbg_addr = 5'd7;
    tick();
    vectors++;
    if (bus.dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: got ack=%b, expected 0", bus.dbg_ack);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({bus.dbg_ack, bus.dbg_rdata} !== {1'b1, e.data}) begin
      miscompares++;
      $display("FAIL b2b_second: got ack=%b rdata=%h, expected ack=1 rdata=%h", bus.dbg_ack, bus.dbg_rdata, e.data);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_sweep();
    test_dbg_write();
    test_wait_stall();
    test_wb_priority();
    test_same_cycle();
    test_xzr();
    test_back_to_back();
    vectors++;
    if (bad31 != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final: got X31 writes=%0d leftover=%0d, expected 0 and 0", bad31, exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
